// File: rtl/alu_arb_pkg.sv
// Shared widths, opcode encoding and default latency for the ALU arbiter slice.
package alu_arb_pkg;

    localparam int DATA_W          = 16;
    localparam int OP_W            = 3;
    localparam int ALU_LAT_DEFAULT = 2;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6
    } alu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts one past last_id and wraps.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_id,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    // Walk requesters in priority order last_id+1 .. last_id; first active one wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            // NUM_REQ is a power of two, so ID_W-bit addition wraps modulo NUM_REQ.
            idx = last_id + ID_W'(k);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one pipelined ALU among NUM_REQ requesters and routes results back by tag.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int ALU_LAT = ALU_LAT_DEFAULT,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OP_W*NUM_REQ-1:0]   req_op,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                      alu_valid_in,
    output logic [OP_W-1:0]           alu_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    input  logic                      alu_valid_out,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_overflow,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_result,
    output logic                      rsp_overflow,
    output logic                      busy,
    output logic [15:0]               grant_cnt,
    output logic                      err
);

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic [ID_W-1:0]    last_id;
    logic               handshake;
    logic [ALU_LAT-1:0] tag_valid;
    logic [ID_W-1:0]    tag_id [ALU_LAT];

    // Gating with rst_n keeps ready/issue low while reset is held, not just after it.
    assign arb_req = (enable && rst_n) ? req_valid : '0;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req      (arb_req),
        .last_id  (last_id),
        .grant    (grant),
        .grant_id (grant_id)
    );

    // A grant is only ever given to a valid requester, so any grant is a handshake.
    assign req_ready    = grant;
    assign handshake    = |grant;
    assign alu_valid_in = handshake;

    // Steer the granted requester's opcode and operands onto the ALU; zero when idle.
    always_comb begin
        alu_op = '0;
        alu_a  = '0;
        alu_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                alu_op = req_op[i*OP_W +: OP_W];
                alu_a  = req_a[i*DATA_W +: DATA_W];
                alu_b  = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    // Round-robin pointer and grant counter advance only on a handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            last_id   <= ID_W'(NUM_REQ - 1);
            grant_cnt <= '0;
        end else if (handshake) begin
            last_id   <= grant_id;
            grant_cnt <= grant_cnt + 16'd1;
        end
    end

    // Valid half of the tag pipeline: cleared on reset so in-flight ops never respond.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= handshake;
            for (int k = 1; k < ALU_LAT; k++) tag_valid[k] <= tag_valid[k-1];
        end
    end

    // Id half of the tag pipeline: travels alongside the valid bits.
    always_ff @(posedge clk) begin
        // NOTE: ids are only observed when their valid bit is set, so this array needs no reset.
        tag_id[0] <= grant_id;
        for (int k = 1; k < ALU_LAT; k++) tag_id[k] <= tag_id[k-1];
    end

    assign rsp_valid    = tag_valid[ALU_LAT-1];
    assign rsp_id       = rsp_valid ? tag_id[ALU_LAT-1] : '0;
    assign rsp_result   = rsp_valid ? alu_result : '0;
    assign rsp_overflow = rsp_valid & alu_overflow;
    assign busy         = |tag_valid;

    // Sticky flag: the ALU's own valid must agree with the expected tag every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (rsp_valid != alu_valid_out) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (power of 2, 2..8).
REQ-002 Parameter ALU_LAT, default 2, fixed ALU issue-to-result latency in cycles.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 enable  input  1  high = new grants allowed; low = no new grants, in-flight ops still complete.
REQ-006 req_valid  input  NUM_REQ  per-requester op request.
REQ-007 req_ready  output  NUM_REQ  per-requester accept; handshake when valid&ready.
REQ-008 req_op  input  3*NUM_REQ  per-requester ALU opcode, slice i = bits [3i+2:3i].
REQ-009 req_a / req_b  input  16*NUM_REQ each  per-requester operands, slice i = bits [16i+15:16i].
REQ-010 alu_valid_in  output  1  issue strobe to the ALU.
REQ-011 alu_op / alu_a / alu_b  output  3/16/16  issued opcode and operands.
REQ-012 alu_valid_out / alu_result / alu_overflow  input  1/16/1  ALU result signals.
REQ-013 rsp_valid / rsp_id / rsp_result / rsp_overflow  output  1/log2(NUM_REQ)/16/1  routed response.
REQ-014 busy  output  1  one or more ops in flight.
REQ-015 grant_cnt  output  16  total accepted requests, wraps at 0xFFFF->0.
REQ-016 err  output  1  sticky latency-mismatch flag.

Function
REQ-017 At most one req_ready bit SHALL be high per cycle; all are low when enable=0 or no req_valid is high.
REQ-018 Grant SHALL be round-robin: search begins at last_id+1 (mod NUM_REQ); the first requester with req_valid=1 gets req_ready=1 in the same cycle (combinational).
REQ-019 last_id SHALL update to the granted id only on a handshake; it is unchanged in idle cycles.
REQ-020 alu_valid_in SHALL equal 1 exactly in handshake cycles; alu_op/a/b SHALL be the granted requester's slices, and all-zero when no grant.
REQ-021 One op SHALL be issued per cycle at most; back-to-back issue with no bubbles is required.
REQ-022 A tag pipeline ALU_LAT deep SHALL carry {valid, id} per issue; a request accepted in cycle N yields rsp_valid=1 in cycle N+ALU_LAT with rsp_id = granted id.
REQ-023 rsp_result/rsp_overflow SHALL pass through alu_result/alu_overflow combinationally when rsp_valid=1, and be zero otherwise.
REQ-024 rsp_valid SHALL follow the tag pipeline output, not alu_valid_out.
REQ-025 If the tag-pipeline output valid differs from alu_valid_out in any cycle, err SHALL set and hold until reset.
REQ-026 busy SHALL be the OR of all tag-pipeline valid bits.
REQ-027 grant_cnt SHALL increment by 1 per handshake.
REQ-028 A requester that holds req_valid high with no ready SHALL keep its request pending; the arbiter SHALL NOT drop it. Each other active requester is granted at most once before it.
REQ-029 enable falling mid-stream SHALL stop grants in that same cycle; responses already in flight SHALL still arrive on schedule.

Reset
REQ-030 On rst_n=0: last_id=NUM_REQ-1 (first grant search starts at requester 0), tag pipeline cleared, grant_cnt=0, err=0.
REQ-031 During reset: rsp_valid=0, busy=0, all req_ready=0, alu_valid_in=0. In-flight ops SHALL be discarded without a response.

Structure
REQ-032 Package alu_arb_pkg SHALL hold the data width (16), opcode width (3), opcode constants (ADD=0 .. SHR=6), and the default ALU_LAT.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (req vector and last_id in; one-hot grant and id out; purely combinational).
REQ-034 Tag pipeline, counters and response routing SHALL reside in alu_arbiter.

Verification
REQ-035 Single request: req 2 issues ADD 0x0003+0x0004 in cycle N -> rsp_valid in cycle N+2, rsp_id=2, rsp_result=0x0007.
REQ-036 All 4 requesters valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3, 8 responses with matching ids, grant_cnt=8.
REQ-037 Requests from 1 and 3 only, last_id=1 -> grant 3 then 1, no grant to an idle requester.
REQ-038 enable dropped with 2 ops in flight -> no further req_ready, both responses arrive, busy falls 2 cycles later.
REQ-039 Force alu_valid_out=0 while a tag is due -> err=1 and stays 1; rsp_valid=1 still asserted.
REQ-040 rst_n asserted with 2 ops in flight -> no rsp_valid afterwards, grant_cnt=0, first grant after reset goes to requester 0.
